eth_10g_mac_tx_stat_collector: RTL

Downstream consumer of the TX status stream from the 10G MAC TX status timing adapter. Accepts one 47-bit status word (40-bit data, 7-bit error) per transmitted frame and accumulates per-class frame and octet statistics. Exposes the counters to the JTAG/CSR fabric through a fixed-latency Avalon-MM slave. Always ready, so the upstream adapter never sees backpressure.

---
 rtl/eth_10g_tx_stat_pkg.sv | 36 +++
 rtl/eth_10g_tx_stat_counter.sv | 28 ++
 rtl/eth_10g_mac_tx_stat_collector.sv | 117 +++++++++++
 3 files changed

// File: rtl/eth_10g_tx_stat_pkg.sv
// Shared field positions, CSR map and stage-1 record for the 10G MAC TX
// statistics collector.
package eth_10g_tx_stat_pkg;

    localparam int unsigned LEN_LSB       = 0;
    localparam int unsigned LEN_MSB       = 15;
    localparam int unsigned BCAST_BIT     = 16;
    localparam int unsigned MCAST_BIT     = 17;
    localparam int unsigned PAUSE_BIT     = 18;
    localparam int unsigned ERR_UNDERFLOW = 0;
    localparam int unsigned ERR_OVERSIZE  = 1;
    localparam int unsigned CLEAR_BIT     = 0;

    localparam logic [3:0] ADDR_FRAMES_OK  = 4'h0;
    localparam logic [3:0] ADDR_FRAMES_ERR = 4'h1;
    localparam logic [3:0] ADDR_OCTETS_LO  = 4'h2;
    localparam logic [3:0] ADDR_OCTETS_HI  = 4'h3;
    localparam logic [3:0] ADDR_BCAST      = 4'h4;
    localparam logic [3:0] ADDR_MCAST      = 4'h5;
    localparam logic [3:0] ADDR_PAUSE      = 4'h6;
    localparam logic [3:0] ADDR_UNDERFLOW  = 4'h7;
    localparam logic [3:0] ADDR_OVERSIZE   = 4'h8;
    localparam logic [3:0] ADDR_CTRL       = 4'hF;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [15:0] len;
        logic        bcast;
        logic        mcast;
        logic        pause;
        logic        underflow;
        logic        oversize;
    } s1_stat_t;

endpackage

// File: rtl/eth_10g_tx_stat_counter.sv
// Wrapping statistics counter; a clear in the same cycle as an increment
// leaves only the increment.
module eth_10g_tx_stat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc_en,
    input  logic [W-1:0] inc_val,
    output logic [W-1:0] cnt
);

    logic [W-1:0] add;

    assign add = inc_en ? inc_val : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= add;
        end else begin
            cnt <= cnt + add;
        end
    end

endmodule

// File: rtl/eth_10g_mac_tx_stat_collector.sv
// TX status stream statistics: stage-1 decode, stage-2 counters, and a
// one-cycle-latency Avalon-MM read port with a coherent octet high-half shadow.
module eth_10g_mac_tx_stat_collector
    import eth_10g_tx_stat_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned OCT_W = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        status_ready,
    input  logic        status_valid,
    input  logic [39:0] status_data,
    input  logic [6:0]  status_error,
    input  logic [3:0]  csr_address,
    input  logic        csr_read,
    output logic [31:0] csr_readdata,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata
);

    s1_stat_t s1;

    logic clr;
    logic ok_en, err_en;

    logic [CNT_W-1:0] frames_ok, frames_err, bcast_ok, mcast_ok, pause_ok;
    logic [CNT_W-1:0] underflow_cnt, oversize_cnt;
    logic [OCT_W-1:0] octets_ok;
    logic [31:0]      shadow;
    logic [31:0]      rd_mux;

    logic unused_bits;
    assign unused_bits = &{1'b0, status_data[39:19], csr_writedata[31:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1           <= '0;
            status_ready <= 1'b0;
        end else begin
            status_ready <= 1'b1;
            s1.valid     <= status_valid;
            s1.err       <= |status_error;
            s1.len       <= status_data[LEN_MSB:LEN_LSB];
            s1.bcast     <= status_data[BCAST_BIT];
            s1.mcast     <= status_data[MCAST_BIT];
            s1.pause     <= status_data[PAUSE_BIT];
            s1.underflow <= status_error[ERR_UNDERFLOW];
            s1.oversize  <= status_error[ERR_OVERSIZE];
        end
    end

    assign clr    = csr_write && (csr_address == ADDR_CTRL) && csr_writedata[CLEAR_BIT];
    assign ok_en  = s1.valid && !s1.err;
    assign err_en = s1.valid && s1.err;

    eth_10g_tx_stat_counter #(.W(CNT_W)) u_frames_ok (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc_en(ok_en),
        .inc_val(CNT_W'(1)), .cnt(frames_ok));
    eth_10g_tx_stat_counter #(.W(CNT_W)) u_frames_err (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc_en(err_en),
        .inc_val(CNT_W'(1)), .cnt(frames_err));
    eth_10g_tx_stat_counter #(.W(CNT_W)) u_bcast (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc_en(ok_en && s1.bcast),
        .inc_val(CNT_W'(1)), .cnt(bcast_ok));
    eth_10g_tx_stat_counter #(.W(CNT_W)) u_mcast (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc_en(ok_en && s1.mcast),
        .inc_val(CNT_W'(1)), .cnt(mcast_ok));
    eth_10g_tx_stat_counter #(.W(CNT_W)) u_pause (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc_en(ok_en && s1.pause),
        .inc_val(CNT_W'(1)), .cnt(pause_ok));
    eth_10g_tx_stat_counter #(.W(CNT_W)) u_underflow (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc_en(err_en && s1.underflow),
        .inc_val(CNT_W'(1)), .cnt(underflow_cnt));
    eth_10g_tx_stat_counter #(.W(CNT_W)) u_oversize (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc_en(err_en && s1.oversize),
        .inc_val(CNT_W'(1)), .cnt(oversize_cnt));
    eth_10g_tx_stat_counter #(.W(OCT_W)) u_octets (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc_en(ok_en),
        .inc_val({{(OCT_W-16){1'b0}}, s1.len}), .cnt(octets_ok));

    // Shadow is taken from the same pre-update snapshot as the low-half read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (clr) begin
            shadow <= '0;
        end else if (csr_read && (csr_address == ADDR_OCTETS_LO)) begin
            shadow <= 32'(octets_ok[OCT_W-1:32]);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            ADDR_FRAMES_OK:  rd_mux = 32'(frames_ok);
            ADDR_FRAMES_ERR: rd_mux = 32'(frames_err);
            ADDR_OCTETS_LO:  rd_mux = octets_ok[31:0];
            ADDR_OCTETS_HI:  rd_mux = shadow;
            ADDR_BCAST:      rd_mux = 32'(bcast_ok);
            ADDR_MCAST:      rd_mux = 32'(mcast_ok);
            ADDR_PAUSE:      rd_mux = 32'(pause_ok);
            ADDR_UNDERFLOW:  rd_mux = 32'(underflow_cnt);
            ADDR_OVERSIZE:   rd_mux = 32'(oversize_cnt);
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_readdata <= '0;
        end else if (csr_read) begin
            csr_readdata <= rd_mux;
        end
    end

endmodule
